// File: rtl/enc8to3_pend_pkg.sv
// enc8to3_pend_pkg
//   Shared constants, handshake state type and popcount helper for the
//   pending-request 8-to-3 encoder.
package enc8to3_pend_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Population count of a request vector (0..N_REQ).
    function automatic logic [CNT_W-1:0] popcnt(input logic [N_REQ-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_REQ; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/enc8to3_pend_prio_enc8.sv
// prio_enc8
//   Combinational 8-input priority encoder.
//   Ports:
//     vec  in  8  request vector
//     idx  out 3  index of the winning set bit (0 when vec is empty)
//     any  out 1  at least one bit of vec is set
//   HI_PRIO=1 picks the highest set bit, HI_PRIO=0 the lowest.
module prio_enc8
    import enc8to3_pend_pkg::*;
#(
    parameter bit HI_PRIO = 1'b1
) (
    input  logic [N_REQ-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    assign any = |vec;

    // Scan order is chosen so the last hit is the winner.
    generate
        if (HI_PRIO) begin : g_hi
            always_comb begin
                idx = '0;
                for (int i = 0; i < N_REQ; i++) begin
                    if (vec[i]) idx = IDX_W'(i);
                end
            end
        end else begin : g_lo
            always_comb begin
                idx = '0;
                for (int i = N_REQ - 1; i >= 0; i--) begin
                    if (vec[i]) idx = IDX_W'(i);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/enc8to3_pend.sv
// enc8to3_pend
//   Sequential 8-to-3 priority encoder with request capture. Request pulses
//   accumulate in a pending register; one index at a time is presented on a
//   valid/ready handshake.
//   Ports:
//     clk       in  1  rising-edge clock
//     rst       in  1  synchronous active-high reset
//     req       in  8  request pulses, req[i] marks index i pending
//     en        in  1  launch enable (capture continues when 0)
//     ready     in  1  consumer accepts code when valid && ready
//     code      out 3  index being presented
//     valid     out 1  code is valid
//     pend      out 8  pending vector, excluding the index held in code
//     pend_cnt  out 4  popcount of pend
module enc8to3_pend
    import enc8to3_pend_pkg::*;
#(
    parameter bit HI_PRIO = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    input  logic             ready,
    output logic [IDX_W-1:0] code,
    output logic             valid,
    output logic [N_REQ-1:0] pend,
    output logic [CNT_W-1:0] pend_cnt
);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] sel;
    logic             pend_any;
    logic             free;
    logic             load;
    logic [N_REQ-1:0] clr_mask;
    logic [N_REQ-1:0] pend_nxt;

    prio_enc8 #(
        .HI_PRIO (HI_PRIO)
    ) u_prio (
        .vec (pend),
        .idx (sel),
        .any (pend_any)
    );

    // Slot is free when nothing is held or the held code leaves this edge.
    assign free = !valid || ready;
    assign load = en && free && pend_any;

    // Clearing the picked bit and OR-ing req afterwards lets a same-cycle
    // request on that bit keep it pending for a later re-presentation.
    assign clr_mask = load ? (N_REQ'(1) << sel) : '0;
    assign pend_nxt = (pend & ~clr_mask) | req;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = PRESENT;
            PRESENT: if (ready) state_nxt = load ? PRESENT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        valid = (state == PRESENT);
    end

    // Code, pending vector and its count
    always_ff @(posedge clk) begin
        if (rst) begin
            code     <= '0;
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            if (load) code <= sel;
            pend     <= pend_nxt;
            pend_cnt <= popcnt(pend_nxt);
        end
    end

endmodule

// File: tb/tb_enc8to3_pend.sv
module tb_enc8to3_pend;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       en;
    logic       ready;

    logic [2:0] code_hi, code_lo;
    logic       valid_hi, valid_lo;
    logic [7:0] pend_hi, pend_lo;
    logic [3:0] cnt_hi, cnt_lo;

    int n_cmp = 0;
    int n_err = 0;

    logic [2:0] exp_hi[$];
    logic [2:0] exp_lo[$];
    logic [2:0] obs_hi[$];
    logic [2:0] obs_lo[$];

    always #5 clk = ~clk;

    enc8to3_pend #(.HI_PRIO(1'b1)) dut_hi (
        .clk(clk), .rst(rst), .req(req), .en(en), .ready(ready),
        .code(code_hi), .valid(valid_hi), .pend(pend_hi), .pend_cnt(cnt_hi)
    );

    enc8to3_pend #(.HI_PRIO(1'b0)) dut_lo (
        .clk(clk), .rst(rst), .req(req), .en(en), .ready(ready),
        .code(code_lo), .valid(valid_lo), .pend(pend_lo), .pend_cnt(cnt_lo)
    );

    // Advance one clock; record codes accepted at that edge.
    task automatic tick();
        if (valid_hi && ready) obs_hi.push_back(code_hi);
        if (valid_lo && ready) obs_lo.push_back(code_lo);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 8'h00; en = 1'b0; ready = 1'b0;
        tick();
        rst = 1'b0;
        exp_hi.delete(); exp_lo.delete(); obs_hi.delete(); obs_lo.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 8'hFF; en = 1'b1; ready = 1'b1;
        tick(); tick();
        rst = 1'b0; req = 8'h00;
        n_cmp++; if (valid_hi !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", valid_hi); end
        n_cmp++; if (pend_hi !== 8'h00) begin n_err++; $display("FAIL reset_pend got %h exp 00", pend_hi); end
        n_cmp++; if (cnt_hi !== 4'd0) begin n_err++; $display("FAIL reset_cnt got %0d exp 0", cnt_hi); end
        n_cmp++; if (code_hi !== 3'd0) begin n_err++; $display("FAIL reset_code got %0d exp 0", code_hi); end
        tick();
        n_cmp++; if (valid_hi !== 1'b0 || pend_hi !== 8'h00) begin n_err++;
            $display("FAIL reset_drop valid=%b pend=%h exp 0/00", valid_hi, pend_hi); end
    endtask

    task automatic test_single();
        do_reset();
        en = 1'b1; ready = 1'b1; req = 8'h20;
        exp_hi.push_back(3'd5);
        tick();
        req = 8'h00;
        n_cmp++; if (pend_hi !== 8'h20 || valid_hi !== 1'b0 || cnt_hi !== 4'd1) begin n_err++;
            $display("FAIL single_capture pend=%h valid=%b cnt=%0d exp 20/0/1", pend_hi, valid_hi, cnt_hi); end
        tick();
        n_cmp++; if (valid_hi !== 1'b1 || code_hi !== 3'd5 || pend_hi !== 8'h00) begin n_err++;
            $display("FAIL single_present valid=%b code=%0d pend=%h exp 1/5/00", valid_hi, code_hi, pend_hi); end
        tick();
        n_cmp++; if (valid_hi !== 1'b0) begin n_err++; $display("FAIL single_idle valid=%b exp 0", valid_hi); end
        while (exp_hi.size() > 0) begin
            logic [2:0] e, o;
            e = exp_hi.pop_front();
            o = (obs_hi.size() > 0) ? obs_hi.pop_front() : 3'bxxx;
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL single_sb got %0d exp %0d", o, e); end
        end
    endtask

    task automatic test_priority();
        logic [3:0] cnt_exp[4];
        cnt_exp = '{4'd3, 4'd2, 4'd1, 4'd0};
        do_reset();
        en = 1'b1; ready = 1'b1; req = 8'h91;
        exp_hi.push_back(3'd7); exp_hi.push_back(3'd4); exp_hi.push_back(3'd0);
        exp_lo.push_back(3'd0); exp_lo.push_back(3'd4); exp_lo.push_back(3'd7);
        tick();
        req = 8'h00;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (cnt_hi !== cnt_exp[i] || cnt_lo !== cnt_exp[i]) begin n_err++;
                $display("FAIL prio_cnt[%0d] hi=%0d lo=%0d exp %0d", i, cnt_hi, cnt_lo, cnt_exp[i]); end
            if (i > 0) begin
                n_cmp++; if (valid_hi !== 1'b1 || valid_lo !== 1'b1) begin n_err++;
                    $display("FAIL prio_bubble[%0d] hi=%b lo=%b exp 1", i, valid_hi, valid_lo); end
            end
            tick();
        end
        n_cmp++; if (valid_hi !== 1'b0) begin n_err++; $display("FAIL prio_idle valid=%b exp 0", valid_hi); end
        while (exp_hi.size() > 0) begin
            logic [2:0] e, o;
            e = exp_hi.pop_front();
            o = (obs_hi.size() > 0) ? obs_hi.pop_front() : 3'bxxx;
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL prio_hi_sb got %0d exp %0d", o, e); end
        end
        while (exp_lo.size() > 0) begin
            logic [2:0] e, o;
            e = exp_lo.pop_front();
            o = (obs_lo.size() > 0) ? obs_lo.pop_front() : 3'bxxx;
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL prio_lo_sb got %0d exp %0d", o, e); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        en = 1'b1; ready = 1'b0; req = 8'h08;
        tick();
        req = 8'h00;
        tick();
        req = 8'h02;
        tick();
        req = 8'h00;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (valid_hi !== 1'b1 || code_hi !== 3'd3 || pend_hi !== 8'h02) begin n_err++;
                $display("FAIL bp_hold[%0d] valid=%b code=%0d pend=%h exp 1/3/02", i, valid_hi, code_hi, pend_hi); end
            tick();
        end
        ready = 1'b1;
        exp_hi.push_back(3'd3); exp_hi.push_back(3'd1);
        tick();
        n_cmp++; if (valid_hi !== 1'b1 || code_hi !== 3'd1) begin n_err++;
            $display("FAIL bp_release valid=%b code=%0d exp 1/1", valid_hi, code_hi); end
        tick();
        while (exp_hi.size() > 0) begin
            logic [2:0] e, o;
            e = exp_hi.pop_front();
            o = (obs_hi.size() > 0) ? obs_hi.pop_front() : 3'bxxx;
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL bp_sb got %0d exp %0d", o, e); end
        end
    endtask

    task automatic test_rearm();
        do_reset();
        en = 1'b1; ready = 1'b1; req = 8'h40;
        exp_hi.push_back(3'd6); exp_hi.push_back(3'd6);
        tick();
        tick();
        req = 8'h00;
        n_cmp++; if (valid_hi !== 1'b1 || code_hi !== 3'd6 || pend_hi !== 8'h40) begin n_err++;
            $display("FAIL rearm_keep valid=%b code=%0d pend=%h exp 1/6/40", valid_hi, code_hi, pend_hi); end
        tick();
        n_cmp++; if (valid_hi !== 1'b1 || code_hi !== 3'd6 || pend_hi !== 8'h00) begin n_err++;
            $display("FAIL rearm_again valid=%b code=%0d pend=%h exp 1/6/00", valid_hi, code_hi, pend_hi); end
        tick();
        n_cmp++; if (valid_hi !== 1'b0) begin n_err++; $display("FAIL rearm_idle valid=%b exp 0", valid_hi); end
        while (exp_hi.size() > 0) begin
            logic [2:0] e, o;
            e = exp_hi.pop_front();
            o = (obs_hi.size() > 0) ? obs_hi.pop_front() : 3'bxxx;
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL rearm_sb got %0d exp %0d", o, e); end
        end
    endtask

    task automatic test_enable_reset();
        do_reset();
        en = 1'b0; ready = 1'b1; req = 8'h0C;
        tick();
        req = 8'h00;
        tick();
        n_cmp++; if (pend_hi !== 8'h0C || valid_hi !== 1'b0 || cnt_hi !== 4'd2) begin n_err++;
            $display("FAIL en_gate pend=%h valid=%b cnt=%0d exp 0C/0/2", pend_hi, valid_hi, cnt_hi); end
        en = 1'b1; ready = 1'b0;
        tick();
        n_cmp++; if (valid_hi !== 1'b1 || code_hi !== 3'd3 || pend_hi !== 8'h04) begin n_err++;
            $display("FAIL en_load valid=%b code=%0d pend=%h exp 1/3/04", valid_hi, code_hi, pend_hi); end
        en = 1'b0;
        tick();
        n_cmp++; if (valid_hi !== 1'b1 || code_hi !== 3'd3) begin n_err++;
            $display("FAIL en_hold valid=%b code=%0d exp 1/3", valid_hi, code_hi); end
        rst = 1'b1; req = 8'h10;
        tick();
        rst = 1'b0; req = 8'h00;
        n_cmp++; if (valid_hi !== 1'b0 || pend_hi !== 8'h00 || cnt_hi !== 4'd0 || code_hi !== 3'd0) begin n_err++;
            $display("FAIL mid_reset valid=%b pend=%h cnt=%0d code=%0d exp 0/00/0/0", valid_hi, pend_hi, cnt_hi, code_hi); end
        n_cmp++; if (obs_hi.size() != 0) begin n_err++;
            $display("FAIL mid_reset_accept got %0d accepts exp 0", obs_hi.size()); end
    endtask

    task automatic test_full();
        do_reset();
        en = 1'b0; ready = 1'b0; req = 8'hFF;
        tick();
        req = 8'h00;
        n_cmp++; if (pend_hi !== 8'hFF || cnt_hi !== 4'd8) begin n_err++;
            $display("FAIL full_cnt pend=%h cnt=%0d exp FF/8", pend_hi, cnt_hi); end
    endtask

    initial begin
        rst = 1'b1; req = 8'h00; en = 1'b0; ready = 1'b0;
        #1;
        test_reset();
        test_single();
        test_priority();
        test_backpressure();
        test_rearm();
        test_enable_reset();
        test_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
